// File: rtl/uart_host_tx.sv
// ---------------------------------------------------------------------------
// uart_host_tx
//   Host-side UART transmitter for simulation and bring-up. Bytes written by a
//   bench or host model are queued in a small FIFO and serialised LSB first
//   onto a single line intended for the Rx pin of riscv_top.
//
//   Frame: start bit, 8 data bits, optional even parity bit, STOP_BITS stops.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       push wr_data into the FIFO this cycle (ignored when full)
//   wr_data     byte to transmit
//   full        FIFO holds FIFO_DEPTH bytes
//   fifo_count  bytes queued, excluding the byte currently on the line
//   overflow    sticky flag: a write arrived while full (cleared by reset)
//   busy        a frame is on the line
//   tx          registered serial line output, idles high
//
// Build option
//   UART_PARITY_EN  when defined, a PARITY state sends even parity after D7.
// ---------------------------------------------------------------------------
module uart_host_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          push;
  logic          pop;

  // Transmitter state
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_reg_nxt;
  logic          tx_nxt;
  logic          baud_last;

  // The write side uses the registered full flag, so a write in the same
  // cycle as a pop from a full FIFO is still rejected.
  assign push       = wr_en & ~full;
  assign baud_last  = (baud_cnt == BAUD_LAST);
  assign fifo_count = count;

  // Next occupancy from the push/pop pair of this cycle
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= CNT_ZERO;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count    <= count_nxt;
      full     <= (count_nxt == CNT_FULL);
      overflow <= overflow | (wr_en & full);
    end
  end

  // FIFO data array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Next-state, counters and pop request for the frame sequencer
  always_comb begin
    state_nxt     = state;
    baud_cnt_nxt  = baud_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    pop           = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_cnt_nxt = BAUD_ZERO;
        bit_idx_nxt  = 3'd0;
        if (count != CNT_ZERO) begin
          pop           = 1'b1;
          shift_reg_nxt = mem[rd_ptr];
          state_nxt     = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_cnt_nxt = BAUD_ZERO;
          bit_idx_nxt  = 3'd0;
          state_nxt    = ST_DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_cnt_nxt = BAUD_ZERO;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = 3'd0;
`ifdef UART_PARITY_EN
            state_nxt   = ST_PARITY;
`else
            state_nxt   = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_cnt_nxt = BAUD_ZERO;
          bit_idx_nxt  = 3'd0;
          state_nxt    = ST_STOP;
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        // bit_idx counts stop bits so the baud counter never exceeds one bit
        if (baud_last) begin
          baud_cnt_nxt = BAUD_ZERO;
          if (bit_idx == STOP_LAST) begin
            bit_idx_nxt = 3'd0;
            state_nxt   = ST_IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_ONE;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        baud_cnt_nxt = BAUD_ZERO;
        bit_idx_nxt  = 3'd0;
      end
    endcase
  end

  // Line level for the current state; registered below, so tx lags state by
  // one cycle (the pop cycle is still idle-high on the line).
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      ST_IDLE:   tx_nxt = 1'b1;
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_reg[bit_idx];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_nxt = even_parity(shift_reg);
`endif
      ST_STOP:   tx_nxt = 1'b1;
      default:   tx_nxt = 1'b1;
    endcase
  end

  // Sequencer state and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= BAUD_ZERO;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_reg_nxt;
      tx        <= tx_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_host_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_host_tx
//   Self-checking bench for uart_host_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   A background receiver decodes frames from tx by ideal mid-bit sampling;
//   expected bytes are the writes seen while full was low.
//   With UART_PARITY_EN defined the DUT is built with STOP_BITS=2.
// ---------------------------------------------------------------------------
module tb_uart_host_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int STOPB = 2;
  localparam int PAR   = 1;
`else
  localparam int STOPB = 1;
  localparam int PAR   = 0;
`endif
  localparam int NBITS = 10 + STOPB - 1 + PAR;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr = 0;
  bit mon_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         fall_q[$];

  uart_host_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .STOP_BITS   (STOPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal receiver: called on the first sample with the line low.
  task automatic mon_frame();
    logic [7:0] b;
    bit ok;
    bit alive;
    int f;
    f = cyc;
    ok = 1'b1;
    alive = 1'b1;
    b = 8'h00;
    repeat (CPB / 2) begin @(posedge clk); #2; if (!rst_n) alive = 1'b0; end
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) begin @(posedge clk); #2; if (!rst_n) alive = 1'b0; end
      b[i] = tx;
    end
`ifdef UART_PARITY_EN
    repeat (CPB) begin @(posedge clk); #2; if (!rst_n) alive = 1'b0; end
    if (tx !== ^b) ok = 1'b0;
`endif
    repeat (CPB) begin @(posedge clk); #2; if (!rst_n) alive = 1'b0; end
    if (tx !== 1'b1) ok = 1'b0;
    if (alive) begin
      rx_q.push_back(b);
      fall_q.push_back(f);
      if (!ok) ferr++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && rst_n && tx === 1'b0) mon_frame();
    end
  end

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
    fall_q.delete();
    ferr = 0;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int w;
    w = 0;
    while (rx_q.size() < n && w < limit) begin
      tick();
      w++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL wait_rx: got %0d frames, expected %0d within %0d clk", rx_q.size(), n, limit);
    end
  endtask

  task automatic compare_rx(input string name);
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d frames, expected %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %02h expected %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ferr !== 0) begin
      errors++;
      $display("FAIL %s_framing: got %0d bad frames expected 0", name, ferr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    checks += 5;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  // Cycle-exact line check for one byte written into an idle, empty block.
  task automatic test_frame(input logic [7:0] d);
    logic exp_bits[16];
    logic exp_tx;
    int busy_cnt;
    int j;
    mon_en = 1'b0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
    if (PAR != 0) exp_bits[9] = ^d;
    for (int i = 9 + PAR; i < 16; i++) exp_bits[i] = 1'b1;
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL frame_count: got %0d expected 1", fifo_count); end
    busy_cnt = 0;
    for (int k = 0; k < FRAME + 10; k++) begin
      j = (k - 2) / CPB;
      if (k < 2 || j >= NBITS) exp_tx = 1'b1;
      else exp_tx = exp_bits[j];
      checks++;
      if (tx !== exp_tx) begin
        errors++;
        $display("FAIL frame_%02h_tx_at_%0d: got %b expected %b", d, k, tx, exp_tx);
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt !== FRAME) begin
      errors++;
      $display("FAIL frame_%02h_busy_len: got %0d expected %0d", d, busy_cnt, FRAME);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes[5];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00; bytes[4] = 8'h81;
    clear_q();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL burst_full_%0d: got %b expected 0", i, full); end
      exp_q.push_back(bytes[i]);
      wr_en = 1'b1;
      wr_data = bytes[i];
      tick();
    end
    wr_en = 1'b0;
    wait_rx(5, 5 * (FRAME + 1) + 40);
    compare_rx("burst");
    for (int i = 0; i + 1 < fall_q.size(); i++) begin
      checks++;
      if (fall_q[i + 1] - fall_q[i] !== FRAME + 1) begin
        errors++;
        $display("FAIL burst_gap_%0d: got %0d clk expected %0d", i, fall_q[i + 1] - fall_q[i], FRAME + 1);
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    clear_q();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (d == 8'h11) d = 8'h12;
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL ovf_fill_full_%0d: got %b expected 0", i, full); end
      exp_q.push_back(d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    checks += 3;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", busy); end
    wait_rx(5, 5 * (FRAME + 1) + 40);
    repeat (FRAME + 10) tick();
    compare_rx("overflow");
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] d;
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      if (i == 0) d[3] = 1'b0;
      wr_en = 1'b1;
      wr_data = d;
      tick();
    end
    wr_en = 1'b0;
    repeat (17) tick();
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b expected 0", tx); end
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    repeat (5) tick();
    rst_n = 1'b1;
    begin
      int lows;
      lows = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (tx !== 1'b1 || fifo_count !== 3'd0) lows++;
      end
      checks++;
      if (lows !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", lows); end
    end
    clear_q();
    mon_en = 1'b1;
    exp_q.push_back(8'h0F);
    wr_en = 1'b1;
    wr_data = 8'h0F;
    tick();
    wr_en = 1'b0;
    wait_rx(1, FRAME + 20);
    compare_rx("mid_after");
    repeat (10) tick();
  endtask

  task automatic test_random();
    logic [7:0] d;
    int gap;
    clear_q();
    mon_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      gap = (i % 6 == 5) ? 3 * FRAME : int'($urandom_range(0, 6));
      repeat (gap) tick();
      d = 8'($urandom);
      if (full === 1'b0) exp_q.push_back(d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
    end
    wait_rx(exp_q.size(), exp_q.size() * (FRAME + 1) + 40);
    repeat (FRAME + 10) tick();
    compare_rx("random");
  endtask

  initial begin
    test_reset();
    test_frame(8'h55);
`ifdef UART_PARITY_EN
    test_frame(8'h07);
`endif
    test_burst();
    test_overflow();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
